// File: rtl/func_dispatcher_seq.sv
// func_dispatcher_seq
//   Sequential user/function dispatcher. A (User, Func) request taken over a
//   Req/Ready handshake is checked against a runtime-programmable permission
//   table. A grant drives the one-hot Matrix and/or Led output for HOLD_CYCLES
//   cycles. A denial pulses Denied. MAX_FAILS consecutive denials lock the
//   block out for LOCK_CYCLES cycles.
//
//   Ports
//     Clock, Reset_n        : rising-edge clock, synchronous active-low reset
//     Req, User, Func       : request valid / requesting user / function code
//     Ready                 : high only in IDLE; accept on Req && Ready
//     Abort                 : ends ACTIVE early (ignored elsewhere)
//     CfgWe, CfgUser,
//     CfgMatMask, CfgLedMask: permission table write port (bit 0 stored as 0)
//     Matrix, Led           : one-hot drives, bit f = function f
//     Granted, Denied,
//     Locked                : status (grant pulse, deny pulse, lockout level)
//
//   Optional build macro FUNC_DISPATCH_AUDIT_EN adds DenyCount (16-bit
//   saturating denial count) and LastDeniedUser (user of the latest denial).
module func_dispatcher_seq #(
  parameter int USER_W      = 3,
  parameter int FUNC_W      = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Req,
  input  logic [USER_W-1:0]    User,
  input  logic [FUNC_W-1:0]    Func,
  output logic                 Ready,
  input  logic                 Abort,
  input  logic                 CfgWe,
  input  logic [USER_W-1:0]    CfgUser,
  input  logic [2**FUNC_W-1:0] CfgMatMask,
  input  logic [2**FUNC_W-1:0] CfgLedMask,
  output logic [2**FUNC_W-1:0] Matrix,
  output logic [2**FUNC_W-1:0] Led,
  output logic                 Granted,
  output logic                 Denied,
  output logic                 Locked
`ifdef FUNC_DISPATCH_AUDIT_EN
  ,
  output logic [15:0]          DenyCount,
  output logic [USER_W-1:0]    LastDeniedUser
`endif
);

  localparam int NU     = 2**USER_W;
  localparam int NF     = 2**FUNC_W;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [NF-1:0] BIT0_CLR = {{(NF-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, CHECK, ACTIVE, DENY, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [USER_W-1:0]   user_p0;
  logic [FUNC_W-1:0]   func_p0;
  logic [NF-1:0]       mat_tbl [NU];
  logic [NF-1:0]       led_tbl [NU];
  logic                mat_bit, led_bit, grant;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [FAIL_W-1:0]   fail_cnt;

  // Reset-time permission masks; codes beyond the table width are dropped.
  function automatic logic [NF-1:0] dflt_mask(input int u, input logic is_mat);
    logic [NF-1:0] m;
    m = '0;
    for (int f = 1; f < NF; f++) begin
      if (is_mat) begin
        if (u == 5) m[f] = 1'b1;
        if (u == 3) m[f] = (f == 1) || (f == 2) || (f == 3) || (f == 4) || (f == 6);
      end else begin
        if (u == 1) m[f] = (f == 1) || (f == 3) || (f == 4) || (f == 6);
        if (u == 6) m[f] = (f == 1) || (f == 6);
      end
    end
    return m;
  endfunction

  function automatic logic [FAIL_W-1:0] fail_sat_inc(input logic [FAIL_W-1:0] c);
    return (c == FAIL_W'(MAX_FAILS)) ? c : c + FAIL_W'(1);
  endfunction

  // Stage 0: accept and latch the request
  always_ff @(posedge Clock) begin
    if (state == IDLE && Req) begin
      user_p0 <= User;
      func_p0 <= Func;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int u = 0; u < NU; u++) begin
        mat_tbl[u] <= dflt_mask(u, 1'b1);
        led_tbl[u] <= dflt_mask(u, 1'b0);
      end
    end else if (CfgWe) begin
      mat_tbl[CfgUser] <= CfgMatMask & BIT0_CLR;
      led_tbl[CfgUser] <= CfgLedMask & BIT0_CLR;
    end
  end

  // Stage 1: permission check; a same-cycle table write lands after this read
  always_comb begin
    mat_bit = mat_tbl[user_p0][func_p0];
    led_bit = led_tbl[user_p0][func_p0];
    grant   = (func_p0 != '0) && (mat_bit || led_bit);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Req) state_nxt = CHECK;
      CHECK:   state_nxt = grant ? ACTIVE : DENY;
      ACTIVE:  if (Abort || hold_cnt == '0) state_nxt = IDLE;
      DENY:    state_nxt = (fail_cnt == FAIL_W'(MAX_FAILS)) ? LOCKED : IDLE;
      LOCKED:  if (lock_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Ready  = (state == IDLE);
    Denied = (state == DENY);
    Locked = (state == LOCKED);
  end

  // Stage 2: registered drives and the hold / lockout / fail counters
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Matrix   <= '0;
      Led      <= '0;
      Granted  <= 1'b0;
      hold_cnt <= '0;
      lock_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      Granted <= (state == CHECK) && grant;
      case (state)
        CHECK: begin
          if (grant) begin
            Matrix   <= {{(NF-1){1'b0}}, mat_bit} << func_p0;
            Led      <= {{(NF-1){1'b0}}, led_bit} << func_p0;
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            fail_cnt <= '0;
          end else begin
            fail_cnt <= fail_sat_inc(fail_cnt);
          end
        end
        ACTIVE: begin
          if (state_nxt == IDLE) begin
            Matrix <= '0;
            Led    <= '0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        DENY:   lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
        LOCKED: begin
          if (lock_cnt == '0) fail_cnt <= '0;
          else                lock_cnt <= lock_cnt - LOCK_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FUNC_DISPATCH_AUDIT_EN
  function automatic logic [15:0] cnt16_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      DenyCount      <= '0;
      LastDeniedUser <= '0;
    end else if (state == CHECK && !grant) begin
      DenyCount      <= cnt16_sat_inc(DenyCount);
      LastDeniedUser <= user_p0;
    end
  end
`endif

endmodule
